// File: rtl/mempool_pkg.sv
// mempool_pkg: shared MemPool DMA types.
//    dma_req_t : one DMA transfer (or chunk) descriptor exchanged between the
//                group DMA frontend, the chunk splitter and the DMA backend.
package mempool_pkg;

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] src;
      logic [31:0] dst;
      logic [31:0] num_bytes;
      logic [3:0]  cache_src;
      logic [3:0]  cache_dst;
      logic [1:0]  burst_src;
      logic [1:0]  burst_dst;
      logic        decouple_rw;
      logic        deburst;
      logic        serialize;
   } dma_req_t;

endpackage

// File: rtl/mempool_dma_chunk_splitter.sv
// mempool_dma_chunk_splitter
//    Splits one arbitrary-length DMA transfer into chunks that never cross a
//    ChunkBytes-aligned destination boundary, bounds the number of chunks in
//    flight to MaxOutstanding and pulses done_o when every chunk completed.
//
// Ports:
//    clk_i          clock
//    rst_ni         synchronous reset, active low (all outputs 0 while low)
//    req_i          transfer request (dma_req_t)
//    req_valid_i    request valid
//    req_ready_o    request accepted when valid && ready (IDLE only)
//    chunk_o        chunk request to the backend
//    chunk_valid_o  chunk valid
//    chunk_ready_i  backend accepts the chunk
//    chunk_done_i   one-cycle pulse per completed chunk, in issue order
//    busy_o         high while a transfer is being split or drained
//    done_o         one-cycle pulse when the transfer is fully complete
module mempool_dma_chunk_splitter
   import mempool_pkg::*;
#(
   parameter int ChunkBytes     = 1024,
   parameter int MaxOutstanding = 8,
   parameter int CntWidth       = $clog2(MaxOutstanding + 1)
) (
   input  logic     clk_i,
   input  logic     rst_ni,
   input  dma_req_t req_i,
   input  logic     req_valid_i,
   output logic     req_ready_o,
   output dma_req_t chunk_o,
   output logic     chunk_valid_o,
   input  logic     chunk_ready_i,
   input  logic     chunk_done_i,
   output logic     busy_o,
   output logic     done_o
);

   localparam logic [31:0]         ChunkSize = 32'(ChunkBytes);
   localparam logic [31:0]         ChunkMask = ChunkSize - 32'd1;
   localparam logic [CntWidth-1:0] MaxOut    = CntWidth'(MaxOutstanding);

   typedef enum logic [1:0] {IDLE, SPLIT, DRAIN} state_t;

   state_t              state_reg;
   dma_req_t            cur_reg;          // num_bytes field doubles as "remaining"
   logic [CntWidth-1:0] outstanding_reg;
   logic [CntWidth-1:0] outstanding_next;
   logic                done_reg;

   logic [31:0] remaining;
   logic [31:0] off;
   logic [31:0] room;
   logic [31:0] len;
   logic        req_hs;
   logic        chunk_hs;
   logic        done_valid;

   assign remaining = cur_reg.num_bytes;
   assign off       = cur_reg.dst & ChunkMask;
   assign room      = ChunkSize - off;
   assign len       = (remaining < room) ? remaining : room;

   // Outputs are forced low while reset is asserted, even though the state
   // registers only clear on the clock edge.
   assign req_ready_o   = rst_ni && (state_reg == IDLE);
   assign chunk_valid_o = rst_ni && (state_reg == SPLIT) && (outstanding_reg != MaxOut);
   assign busy_o        = rst_ni && (state_reg != IDLE);
   assign done_o        = rst_ni && done_reg;

   assign req_hs   = req_valid_i && req_ready_o;
   assign chunk_hs = chunk_valid_o && chunk_ready_i;

   // Completions with nothing in flight are spurious and must not underflow.
   assign done_valid = chunk_done_i && (outstanding_reg != '0);

   always_comb begin
      chunk_o           = cur_reg;
      chunk_o.num_bytes = len;
      if (!rst_ni) begin
         chunk_o = '0;
      end
   end

   always_comb begin
      outstanding_next = outstanding_reg;
      if (chunk_hs && !done_valid) begin
         outstanding_next = outstanding_reg + CntWidth'(1);
      end else if (done_valid && !chunk_hs) begin
         outstanding_next = outstanding_reg - CntWidth'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_reg       <= IDLE;
         cur_reg         <= '0;
         outstanding_reg <= '0;
         done_reg        <= 1'b0;
      end else begin
         done_reg        <= 1'b0;
         outstanding_reg <= outstanding_next;
         case (state_reg)
            IDLE: begin
               if (req_hs) begin
                  if (req_i.num_bytes == 32'd0) begin
                     done_reg <= 1'b1;
                  end else begin
                     cur_reg   <= req_i;
                     state_reg <= SPLIT;
                  end
               end
            end
            SPLIT: begin
               if (chunk_hs) begin
                  cur_reg.src       <= cur_reg.src + len;
                  cur_reg.dst       <= cur_reg.dst + len;
                  cur_reg.num_bytes <= remaining - len;
                  if (len == remaining) begin
                     state_reg <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               // The last completion can retire the transfer in the same cycle
               // it arrives, so done_o lands on the first IDLE cycle.
               if ((outstanding_reg == '0) ||
                   ((outstanding_reg == CntWidth'(1)) && chunk_done_i && !chunk_hs)) begin
                  state_reg <= IDLE;
                  done_reg  <= 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Simulation-only sanity checks.
   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         assert ((ChunkBytes >= 4) && ((ChunkBytes & (ChunkBytes - 1)) == 0))
            else $error("ChunkBytes must be a power of two >= 4");
         assert (!(chunk_done_i && (outstanding_reg == '0)))
            else $warning("spurious chunk_done_i with no chunk in flight ignored");
         if (chunk_valid_o) begin
            assert (len != 32'd0)
               else $error("zero-length chunk issued");
            assert ((off + len) <= ChunkSize)
               else $error("chunk crosses a ChunkBytes boundary");
         end
      end
   end

endmodule

// File: tb/tb_mempool_dma_chunk_splitter.sv
// Directed testbench for mempool_dma_chunk_splitter (ChunkBytes=1024,
// MaxOutstanding=2). Inputs change 1 ns after the rising edge; outputs are
// checked at that same point, where they reflect the freshly updated state.
module tb_mempool_dma_chunk_splitter;
   import mempool_pkg::*;

   logic     clk_i = 1'b0;
   logic     rst_ni = 1'b0;
   dma_req_t req_i;
   logic     req_valid_i = 1'b0;
   logic     req_ready_o;
   dma_req_t chunk_o;
   logic     chunk_valid_o;
   logic     chunk_ready_i = 1'b0;
   logic     chunk_done_i = 1'b0;
   logic     busy_o;
   logic     done_o;

   int tests_run = 0;
   int tests_failed = 0;

   mempool_dma_chunk_splitter #(
      .ChunkBytes    (1024),
      .MaxOutstanding(2)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .req_i        (req_i),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .chunk_o      (chunk_o),
      .chunk_valid_o(chunk_valid_o),
      .chunk_ready_i(chunk_ready_i),
      .chunk_done_i (chunk_done_i),
      .busy_o       (busy_o),
      .done_o       (done_o)
   );

   always #5 clk_i = ~clk_i;

   // One line per transaction.
   always @(negedge clk_i) begin
      if (rst_ni) begin
         if (req_valid_i && req_ready_o)
            $display("[TB] request id=%0d src=%h dst=%h bytes=%h", req_i.id, req_i.src, req_i.dst, req_i.num_bytes);
         if (chunk_valid_o && chunk_ready_i)
            $display("[TB] chunk id=%0d src=%h dst=%h len=%h", chunk_o.id, chunk_o.src, chunk_o.dst, chunk_o.num_bytes);
         if (done_o)
            $display("[TB] transfer done");
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_chunk(input string tag, input logic [31:0] src,
                              input logic [31:0] dst, input logic [31:0] len);
      chk({tag, "_valid"}, 32'(chunk_valid_o), 32'd1);
      chk({tag, "_src"}, chunk_o.src, src);
      chk({tag, "_dst"}, chunk_o.dst, dst);
      chk({tag, "_len"}, chunk_o.num_bytes, len);
   endtask

   task automatic set_req(input logic [3:0] id, input logic [31:0] src,
                          input logic [31:0] dst, input logic [31:0] nb);
      req_i             = '0;
      req_i.id          = id;
      req_i.src         = src;
      req_i.dst         = dst;
      req_i.num_bytes   = nb;
      req_i.cache_src   = 4'h3;
      req_i.cache_dst   = 4'hC;
      req_i.burst_src   = 2'b01;
      req_i.burst_dst   = 2'b10;
      req_i.decouple_rw = 1'b1;
      req_i.deburst     = 1'b0;
      req_i.serialize   = 1'b1;
   endtask

   initial begin
      req_i = '0;

      // Reset behaviour
      tick();
      tick();
      chk("rst_ready", 32'(req_ready_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_valid", 32'(chunk_valid_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_chunk_len", chunk_o.num_bytes, 32'd0);
      rst_ni = 1'b1;
      tick();
      chk("post_rst_ready", 32'(req_ready_o), 32'd1);
      chk("post_rst_busy", 32'(busy_o), 32'd0);
      chk("post_rst_valid", 32'(chunk_valid_o), 32'd0);
      chk("post_rst_done", 32'(done_o), 32'd0);

      // Boundary split: 0x300 bytes starting 0x100 below a 1 KiB boundary
      set_req(4'd5, 32'h8000_0000, 32'h1000_0F00, 32'h300);
      req_valid_i   = 1'b1;
      chunk_ready_i = 1'b1;
      tick();
      req_valid_i = 1'b0;
      chk("split_ready_low", 32'(req_ready_o), 32'd0);
      chk("split_busy", 32'(busy_o), 32'd1);
      check_chunk("split_c0", 32'h8000_0000, 32'h1000_0F00, 32'h100);
      chk("split_c0_id", 32'(chunk_o.id), 32'd5);
      chk("split_c0_cache_src", 32'(chunk_o.cache_src), 32'h3);
      chk("split_c0_burst_dst", 32'(chunk_o.burst_dst), 32'h2);
      chk("split_c0_serialize", 32'(chunk_o.serialize), 32'd1);
      tick();
      check_chunk("split_c1", 32'h8000_0100, 32'h1000_1000, 32'h200);
      tick();
      chunk_ready_i = 1'b0;
      chk("split_drain_valid", 32'(chunk_valid_o), 32'd0);
      chk("split_drain_busy", 32'(busy_o), 32'd1);
      chunk_done_i = 1'b1;
      tick();
      chunk_done_i = 1'b0;
      chk("split_no_done_after_1st", 32'(done_o), 32'd0);
      tick();
      chk("split_no_done_gap", 32'(done_o), 32'd0);
      chunk_done_i = 1'b1;
      tick();
      chunk_done_i = 1'b0;
      chk("split_done", 32'(done_o), 32'd1);
      chk("split_done_ready", 32'(req_ready_o), 32'd1);
      chk("split_done_busy", 32'(busy_o), 32'd0);
      tick();
      chk("split_done_one_cycle", 32'(done_o), 32'd0);

      // Backpressure: chunk0 held for 5 cycles with ready low
      set_req(4'd6, 32'h8000_0000, 32'h1000_0F00, 32'h300);
      req_valid_i = 1'b1;
      tick();
      req_valid_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check_chunk($sformatf("bp_hold%0d", i), 32'h8000_0000, 32'h1000_0F00, 32'h100);
         chk($sformatf("bp_hold%0d_id", i), 32'(chunk_o.id), 32'd6);
         tick();
      end
      chunk_ready_i = 1'b1;
      check_chunk("bp_before_accept", 32'h8000_0000, 32'h1000_0F00, 32'h100);
      tick();
      check_chunk("bp_c1", 32'h8000_0100, 32'h1000_1000, 32'h200);
      tick();
      chunk_ready_i = 1'b0;
      chk("bp_drain_valid", 32'(chunk_valid_o), 32'd0);
      // Two back-to-back completions; the second arrives in DRAIN with one left
      chunk_done_i = 1'b1;
      tick();
      chk("bp_no_done_mid", 32'(done_o), 32'd0);
      tick();
      chunk_done_i = 1'b0;
      chk("bp_done", 32'(done_o), 32'd1);
      chk("bp_done_ready", 32'(req_ready_o), 32'd1);

      // Zero-length request presented in the done_o cycle
      set_req(4'd7, 32'h0, 32'h0, 32'h0);
      req_valid_i = 1'b1;
      tick();
      req_valid_i = 1'b0;
      chk("zero_done", 32'(done_o), 32'd1);
      chk("zero_no_chunk", 32'(chunk_valid_o), 32'd0);
      chk("zero_busy", 32'(busy_o), 32'd0);
      tick();
      chk("zero_done_one_cycle", 32'(done_o), 32'd0);
      chk("zero_still_no_chunk", 32'(chunk_valid_o), 32'd0);

      // Outstanding cap: 4 KiB aligned, only 2 in flight
      set_req(4'd1, 32'h3000_0000, 32'h2000_0000, 32'h1000);
      req_valid_i   = 1'b1;
      chunk_ready_i = 1'b1;
      tick();
      req_valid_i = 1'b0;
      check_chunk("cap_c0", 32'h3000_0000, 32'h2000_0000, 32'h400);
      tick();
      check_chunk("cap_c1", 32'h3000_0400, 32'h2000_0400, 32'h400);
      tick();
      chk("cap_stall0", 32'(chunk_valid_o), 32'd0);
      tick();
      chk("cap_stall1", 32'(chunk_valid_o), 32'd0);
      chunk_done_i = 1'b1;
      tick();
      chunk_done_i = 1'b0;
      check_chunk("cap_c2", 32'h3000_0800, 32'h2000_0800, 32'h400);
      tick();
      chk("cap_stall2", 32'(chunk_valid_o), 32'd0);
      chunk_done_i = 1'b1;
      tick();
      chunk_done_i = 1'b0;
      check_chunk("cap_c3", 32'h3000_0C00, 32'h2000_0C00, 32'h400);
      // Completion coincides with the last handshake: count stays at 1
      chunk_done_i = 1'b1;
      tick();
      chunk_done_i  = 1'b0;
      chunk_ready_i = 1'b0;
      chk("cap_sim_valid", 32'(chunk_valid_o), 32'd0);
      chk("cap_sim_busy", 32'(busy_o), 32'd1);
      chk("cap_sim_no_done", 32'(done_o), 32'd0);
      tick();
      chk("cap_no_early_done", 32'(done_o), 32'd0);
      chk("cap_drain_busy", 32'(busy_o), 32'd1);
      chunk_done_i = 1'b1;
      tick();
      chunk_done_i = 1'b0;
      chk("cap_done", 32'(done_o), 32'd1);
      chk("cap_done_ready", 32'(req_ready_o), 32'd1);

      // Reset mid-operation after chunk0 issued
      set_req(4'd9, 32'h8000_0000, 32'h1000_0F00, 32'h300);
      req_valid_i   = 1'b1;
      chunk_ready_i = 1'b1;
      tick();
      req_valid_i = 1'b0;
      chk("mid_c0_valid", 32'(chunk_valid_o), 32'd1);
      tick();
      rst_ni        = 1'b0;
      chunk_ready_i = 1'b0;
      tick();
      chk("mid_rst_valid", 32'(chunk_valid_o), 32'd0);
      chk("mid_rst_busy", 32'(busy_o), 32'd0);
      chk("mid_rst_ready", 32'(req_ready_o), 32'd0);
      rst_ni = 1'b1;
      tick();
      chk("mid_post_ready", 32'(req_ready_o), 32'd1);
      chk("mid_post_busy", 32'(busy_o), 32'd0);
      chk("mid_post_done", 32'(done_o), 32'd0);
      chunk_done_i = 1'b1;
      tick();
      chunk_done_i = 1'b0;
      chk("stale_no_done", 32'(done_o), 32'd0);
      chk("stale_busy", 32'(busy_o), 32'd0);
      set_req(4'd2, 32'h0000_0100, 32'h1000_0010, 32'h40);
      req_valid_i   = 1'b1;
      chunk_ready_i = 1'b1;
      tick();
      req_valid_i = 1'b0;
      check_chunk("new_c0", 32'h0000_0100, 32'h1000_0010, 32'h40);
      tick();
      chunk_ready_i = 1'b0;
      chk("new_drain_valid", 32'(chunk_valid_o), 32'd0);
      tick();
      chk("new_no_early_done", 32'(done_o), 32'd0);
      chk("new_drain_busy", 32'(busy_o), 32'd1);
      chunk_done_i = 1'b1;
      tick();
      chunk_done_i = 1'b0;
      chk("new_done", 32'(done_o), 32'd1);
      tick();
      chk("new_done_one_cycle", 32'(done_o), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
